led_seq_ctrl: RTL and testbench

- Sequencer directly upstream of the 16-LED position/pattern mapper; drives its pos[2:0] and patt[3:0] inputs.
- A prescaler sets the step rate. Each step advances pos through the 8 position codes.
- When pos wraps, patt is updated according to the selected pattern mode.
- Supports free-run, hold, and manual single-step operation from a board push-button.

---
 rtl/led_seq_pkg.sv | 32 +++
 rtl/led_tick_gen.sv | 32 +++
 rtl/led_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_led_seq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED position/pattern sequencer.
// The pattern-update rule applied on a position wrap is also defined here.
package led_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_ROT  = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    localparam logic [2:0] POS_MAX = 3'd7;

    // Pattern produced when pos wraps under the given mode.
    function automatic logic [3:0] wrap_patt(input logic [3:0] patt, input logic [1:0] mode);
        logic [3:0] res;
        res = patt;
        case (mode)
            MODE_CNT:  res = patt + 4'd1;
            MODE_ROT:  res = {patt[2:0], patt[3]};
            MODE_INV:  res = ~patt;
            MODE_HOLD: res = patt;
            default:   res = patt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Freezeable step-rate prescaler: counts 0..DIV-1 while run is high, holds otherwise.
// tick is high for the single cycle the count sits at DIV-1.
module led_tick_gen #(
    parameter int DIV   = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_cnt,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // The count can only reach DIV-1 while running, and it always returns
    // to 0 on the following edge, so a tick is never left pending in a freeze.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Sequencer feeding the 16-LED mapper: steps pos through 8 codes and updates
// patt on each wrap, in free-run, hold or manual single-step operation.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int         DIV       = 50_000_000,
    parameter int         CNT_W     = 26,
    parameter logic [3:0] PATT_INIT = 4'b0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       start,
    input  logic       en,
    input  logic       step,
    input  logic       dir,
    input  logic [1:0] mode,
    output logic [2:0] pos,
    output logic [3:0] patt,
    output logic       running,
    output logic       wrap
);

    state_t     state;
    state_t     state_nxt;
    logic       start_q;
    logic       step_q;
    logic       start_edge;
    logic       step_edge;
    logic       tick;
    logic       cnt_run;
    logic       clr_cnt;
    logic       adv;
    logic       at_end;
    logic       wrap_nxt;
    logic [2:0] pos_nxt;
    logic [3:0] patt_nxt;

    assign start_edge = start & ~start_q;
    assign step_edge  = step & ~step_q;
    assign running    = (state == S_RUN);

    led_tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr_cnt (clr_cnt),
        .run     (cnt_run),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        cnt_run   = 1'b0;
        // Holding the prescaler at 0 throughout IDLE covers the clear on exit.
        clr_cnt   = clr || (state == S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_nxt = en ? S_RUN : S_HOLD;
                end
            end
            S_RUN: begin
                cnt_run = en;
                adv     = tick;
                if (!en) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (en) begin
                    state_nxt = S_RUN;
                end else if (step_edge) begin
                    adv = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        at_end   = dir ? (pos == 3'd0) : (pos == POS_MAX);
        wrap_nxt = adv && at_end;
        pos_nxt  = pos;
        if (adv) begin
            pos_nxt = dir ? (pos - 3'd1) : (pos + 3'd1);
        end
        patt_nxt = wrap_nxt ? wrap_patt(patt, mode) : patt;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state   <= S_IDLE;
            pos     <= 3'd0;
            patt    <= PATT_INIT;
            wrap    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pos     <= pos_nxt;
            patt    <= patt_nxt;
            wrap    <= wrap_nxt;
            start_q <= start;
        end
    end

    // clr leaves the step history alone so a held button does not re-trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench: a per-cycle behavioural model queues expected outputs,
// and a negedge monitor pops and compares them against the sequencer.
module tb_led_seq_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst, clr, start, en, step, dir;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [3:0] patt;
    logic       running, wrap;

    led_seq_ctrl #(
        .DIV       (DIV),
        .CNT_W     (3),
        .PATT_INIT (4'b0001)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .start   (start),
        .en      (en),
        .step    (step),
        .dir     (dir),
        .mode    (mode),
        .pos     (pos),
        .patt    (patt),
        .running (running),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int patt;
        bit running;
        bit wrap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Stimulus settings applied on each cycle.
    bit b_rst, b_clr, b_start, b_en, b_step, b_dir;
    int b_mode;

    // Reference model: phase 0 = idle, 1 = running, 2 = holding.
    int m_phase, m_cnt, m_pos, m_patt;
    bit m_start_prev, m_step_prev;

    task automatic model_cycle(output exp_t x);
        bit s_edge, t_edge, adv, wr;
        s_edge = b_start && !m_start_prev;
        t_edge = b_step && !m_step_prev;
        adv = 0;
        wr  = 0;
        if (b_rst || b_clr) begin
            m_phase = 0;
            m_cnt = 0;
            m_pos = 0;
            m_patt = 1;
            m_start_prev = 0;
            m_step_prev = b_rst ? 1'b0 : b_step;
        end else begin
            if (m_phase == 0) begin
                if (s_edge) begin
                    m_phase = b_en ? 1 : 2;
                    m_cnt = 0;
                end
            end else if (m_phase == 1) begin
                if (m_cnt == DIV - 1) begin
                    adv = 1;
                    m_cnt = 0;
                end else if (b_en) begin
                    m_cnt = m_cnt + 1;
                end
                if (!b_en) m_phase = 2;
            end else begin
                if (b_en) m_phase = 1;
                else if (t_edge) adv = 1;
            end
            if (adv) begin
                wr = b_dir ? (m_pos == 0) : (m_pos == 7);
                m_pos = b_dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
                if (wr) begin
                    case (b_mode)
                        0: m_patt = (m_patt + 1) % 16;
                        1: m_patt = (m_patt * 2) % 16 + m_patt / 8;
                        2: m_patt = 15 - m_patt;
                        default: m_patt = m_patt;
                    endcase
                end
            end
            m_start_prev = b_start;
            m_step_prev  = b_step;
        end
        x.pos = m_pos;
        x.patt = m_patt;
        x.running = (m_phase == 1);
        x.wrap = wr;
    endtask

    task automatic run_cycles(input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            rst   = b_rst;
            clr   = b_clr;
            start = b_start;
            en    = b_en;
            step  = b_step;
            dir   = b_dir;
            mode  = 2'(b_mode);
            model_cycle(x);
            q.push_back(x);
        end
    endtask

    // Monitor: outputs are registered, so one expected entry per clock.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                n_checks++;
                if (int'(pos) != x.pos || int'(patt) != x.patt ||
                    running != x.running || wrap != x.wrap) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got pos=%0d patt=%b running=%0b wrap=%0b, expected pos=%0d patt=%b running=%0b wrap=%0b",
                             $time, pos, patt, running, wrap, x.pos, 4'(x.patt), x.running, x.wrap);
                end
            end
        end
    end

    initial begin
        rst = 1; clr = 0; start = 0; en = 0; step = 0; dir = 0; mode = 2'd0;
        b_rst = 1; b_clr = 0; b_start = 0; b_en = 0; b_step = 0; b_dir = 0; b_mode = 0;
        m_phase = 0; m_cnt = 0; m_pos = 0; m_patt = 1; m_start_prev = 0; m_step_prev = 0;
        run_cycles(3);
        b_rst = 0;
        run_cycles(2);

        // Free run forward through a full wrap (mode count).
        b_start = 1; b_en = 1;
        run_cycles(36);

        // Reverse with rotate: 0 -> 7 wraps, then 7 -> 6.
        b_dir = 1; b_mode = 1;
        run_cycles(9);

        // Pause mid-count and resume.
        b_en = 0;
        run_cycles(10);
        b_en = 1;
        run_cycles(9);

        // Manual stepping in hold.
        b_en = 0; b_dir = 0; b_mode = 0;
        run_cycles(3);
        b_step = 1; run_cycles(20);
        b_step = 0; run_cycles(2);
        b_step = 1; run_cycles(2);
        b_step = 0; run_cycles(2);
        b_step = 1; b_en = 1; run_cycles(6);
        b_step = 0;

        // Invert then hold-pattern modes across several wraps.
        b_mode = 2; run_cycles(40);
        b_mode = 3; run_cycles(70);

        // start edge in RUN is ignored, then clr mid-run.
        b_start = 0; run_cycles(1);
        b_start = 1; run_cycles(5);
        b_clr = 1; run_cycles(1);
        b_clr = 0; b_start = 0; run_cycles(4);

        // Randomized operation.
        for (int i = 0; i < 3000; i++) begin
            b_rst = ($urandom_range(0, 299) == 0);
            b_clr = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) b_start = ~b_start;
            if ($urandom_range(0, 24) == 0) b_en = ~b_en;
            if ($urandom_range(0, 3) == 0) b_step = ~b_step;
            if ($urandom_range(0, 29) == 0) b_dir = ~b_dir;
            if ($urandom_range(0, 19) == 0) b_mode = int'($urandom_range(0, 3));
            run_cycles(1);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
